// File: rtl/duty_ramp_pwm.sv
// duty_ramp_pwm: multi-channel breathing-LED level ramps driven by a
// shared step prescaler, with a shared counter turning levels into PWM.
module duty_ramp_pwm #(
  parameter int CH         = 4,
  parameter int LEVEL_W    = 4,
  parameter int MAX_LEVEL  = 10,
  parameter int STEP_W     = 10,
  parameter int PHASE_STEP = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [STEP_W-1:0]       step_div,
  input  logic [STEP_W-1:0]       hold_top,
  output logic [CH*LEVEL_W-1:0]   duty_cycle,
  output logic [CH-1:0]           pwm_out,
  output logic                    step_tick,
  output logic [CH-1:0]           cycle_done
);

  localparam logic [LEVEL_W-1:0] MAX_L   = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] PWM_TOP = LEVEL_W'(MAX_LEVEL - 1);

  typedef enum logic [1:0] {
    UP   = 2'd0,
    HOLD = 2'd1,
    DOWN = 2'd2
  } ch_state_e;

  logic [STEP_W-1:0]  presc_q;
  logic [LEVEL_W-1:0] pwm_cnt_q;
  logic               tick;

  ch_state_e          state_q [CH];
  ch_state_e          state_d [CH];
  logic [LEVEL_W-1:0] level_q [CH];
  logic [LEVEL_W-1:0] level_d [CH];
  logic [STEP_W-1:0]  hold_q  [CH];
  logic [STEP_W-1:0]  hold_d  [CH];
  logic [CH-1:0]      done_d;
  logic [CH-1:0]      pwm_d;

  function automatic logic [LEVEL_W-1:0] rst_level(input int i);
    int v;
    v = i * PHASE_STEP;
    if (v > MAX_LEVEL) v = MAX_LEVEL;
    return LEVEL_W'(v);
  endfunction

  // Equality compare: lowering step_div under the count lets it wrap.
  assign tick = en && (presc_q == step_div);

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      level_d[i] = level_q[i];
      hold_d[i]  = hold_q[i];
      done_d[i]  = 1'b0;
      pwm_d[i]   = en && (pwm_cnt_q < level_q[i]);
      if (tick) begin
        unique case (state_q[i])
          UP: begin
            if (level_q[i] < MAX_L) begin
              level_d[i] = level_q[i] + LEVEL_W'(1);
            end else begin
              state_d[i] = HOLD;
              hold_d[i]  = '0;
            end
          end
          HOLD: begin
            if (hold_q[i] >= hold_top) begin
              if (mode) begin
                level_d[i] = '0;
                state_d[i] = UP;
                done_d[i]  = 1'b1;
              end else begin
                state_d[i] = DOWN;
              end
            end else begin
              hold_d[i] = hold_q[i] + STEP_W'(1);
            end
          end
          DOWN: begin
            if (mode) begin
              state_d[i] = UP;
            end else if (level_q[i] != '0) begin
              level_d[i] = level_q[i] - LEVEL_W'(1);
            end else begin
              state_d[i] = UP;
              done_d[i]  = 1'b1;
            end
          end
          default: state_d[i] = UP;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      step_tick  <= 1'b0;
      pwm_out    <= '0;
      cycle_done <= '0;
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= UP;
        level_q[i] <= rst_level(i);
        hold_q[i]  <= '0;
      end
    end else begin
      step_tick  <= tick;
      cycle_done <= done_d;
      pwm_out    <= pwm_d;
      if (en) begin
        presc_q   <= tick ? '0 : presc_q + STEP_W'(1);
        pwm_cnt_q <= (pwm_cnt_q == PWM_TOP) ? '0
                   : pwm_cnt_q + LEVEL_W'(1);
      end
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        level_q[i] <= level_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign duty_cycle[g*LEVEL_W +: LEVEL_W] = level_q[g];

    a_level_range: assert property (
      @(posedge clk) disable iff (rst) level_q[g] <= MAX_L
    );
  end

endmodule

// File: tb/tb_duty_ramp_pwm.sv
// tb_duty_ramp_pwm: directed vector table plus hand sequences
// for dwell, sawtooth, PWM duty, pause, reset and mode change.
module tb_duty_ramp_pwm;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [9:0]  step_div;
  logic [9:0]  hold_top;
  logic [15:0] duty_cycle;
  logic [3:0]  pwm_out;
  logic        step_tick;
  logic [3:0]  cycle_done;

  int n_cmp;
  int n_bad;

  duty_ramp_pwm dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .step_div   (step_div),
    .hold_top   (hold_top),
    .duty_cycle (duty_cycle),
    .pwm_out    (pwm_out),
    .step_tick  (step_tick),
    .cycle_done (cycle_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [15:0] duty;
    logic [3:0]  done;
  } vec_t;

  vec_t vt [13];

  function automatic logic [15:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d, input int h, input logic m);
    rst      = 1'b1;
    en       = 1'b1;
    mode     = m;
    step_div = 10'(d);
    hold_top = 10'(h);
    clk1();
    clk1();
    rst = 1'b0;
  endtask

  // Counts pwm_out highs per channel over n edges.
  task automatic pwm_count(input int n, output int c0, output int c1,
                           output int c2, output int c3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int e = 0; e < n; e++) begin
      clk1();
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
      c2 += int'(pwm_out[2]);
      c3 += int'(pwm_out[3]);
    end
  endtask

  initial begin
    int cur, tn, edges, t1, t2, ticks;
    int c0, c1, c2, c3;
    int lv [0:40];
    int lv3 [0:40];
    logic [3:0] dn [0:40];
    logic early_done, done28, ok_duty, ok_pwm, ok_tick;
    logic [15:0] snap;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b0;
    step_div = '0; hold_top = '0;

    vt[0]  = '{0,  pk(0, 2, 4, 6),   4'b0000};
    vt[1]  = '{4,  pk(4, 6, 8, 10),  4'b0000};
    vt[2]  = '{5,  pk(5, 7, 9, 10),  4'b0000};
    vt[3]  = '{6,  pk(6, 8, 10, 10), 4'b0000};
    vt[4]  = '{7,  pk(7, 9, 10, 9),  4'b0000};
    vt[5]  = '{10, pk(10, 10, 8, 6), 4'b0000};
    vt[6]  = '{11, pk(10, 9, 7, 5),  4'b0000};
    vt[7]  = '{12, pk(10, 8, 6, 4),  4'b0000};
    vt[8]  = '{17, pk(5, 3, 1, 0),   4'b1000};
    vt[9]  = '{19, pk(3, 1, 0, 2),   4'b0100};
    vt[10] = '{21, pk(1, 0, 2, 4),   4'b0010};
    vt[11] = '{22, pk(0, 1, 3, 5),   4'b0000};
    vt[12] = '{23, pk(0, 2, 4, 6),   4'b0001};

    // Triangle, tick every clock, no dwell.
    do_reset(0, 0, 1'b0);
    check("reset pwm_out", 32'(pwm_out), 0);
    check("reset step_tick", 32'(step_tick), 0);
    cur = 0;
    for (int i = 0; i < 13; i++) begin
      while (cur < vt[i].k) begin
        clk1();
        cur++;
      end
      check($sformatf("vec%0d duty", i), 32'(duty_cycle), 32'(vt[i].duty));
      check($sformatf("vec%0d done", i), 32'(cycle_done), 32'(vt[i].done));
      if (vt[i].k > 0)
        check($sformatf("vec%0d tick", i), 32'(step_tick), 1);
    end

    // Slow stepping with extended dwell.
    do_reset(3, 5, 1'b0);
    tn = 0; edges = 0; t1 = 0; t2 = 0;
    early_done = 1'b0; done28 = 1'b0;
    while (tn < 28 && edges < 300) begin
      clk1();
      edges++;
      if (step_tick) begin
        tn++;
        if (tn == 1) t1 = edges;
        if (tn == 2) t2 = edges;
        lv[tn] = int'(duty_cycle[3:0]);
        if (tn == 28) done28 = cycle_done[0];
        else if (cycle_done[0]) early_done = 1'b1;
      end
    end
    check("dwell tick count", 32'(tn), 28);
    check("dwell first tick", 32'(t1), 4);
    check("dwell tick spacing", 32'(t2 - t1), 4);
    check("dwell lv t10", 32'(lv[10]), 10);
    check("dwell lv t17", 32'(lv[17]), 10);
    check("dwell lv t18", 32'(lv[18]), 9);
    check("dwell lv t27", 32'(lv[27]), 0);
    check("dwell done t28", 32'(done28), 1);
    check("dwell no early done", 32'(early_done), 0);
    check("dwell period clocks", 32'(edges), 112);

    // Sawtooth.
    do_reset(0, 0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      clk1();
      lv[k]  = int'(duty_cycle[3:0]);
      lv3[k] = int'(duty_cycle[15:12]);
      dn[k]  = cycle_done;
    end
    check("saw ch0 t10", 32'(lv[10]), 10);
    check("saw ch0 t11", 32'(lv[11]), 10);
    check("saw ch0 t11 done", 32'(dn[11][0]), 0);
    check("saw ch0 t12", 32'(lv[12]), 0);
    check("saw ch0 t12 done", 32'(dn[12][0]), 1);
    check("saw ch3 t4", 32'(lv3[4]), 10);
    check("saw ch3 t6", 32'(lv3[6]), 0);
    check("saw ch3 t6 done", 32'(dn[6][3]), 1);

    // PWM duty with levels frozen by a long step period.
    do_reset(0, 0, 1'b0);
    for (int e = 0; e < 3; e++) clk1();
    step_div = 10'd1000;
    check("pwmA duty", 32'(duty_cycle), 32'(pk(3, 5, 7, 9)));
    clk1();
    pwm_count(20, c0, c1, c2, c3);
    check("pwmA ch0 lvl3", 32'(c0), 6);
    check("pwmA ch1 lvl5", 32'(c1), 10);
    check("pwmA ch2 lvl7", 32'(c2), 14);
    check("pwmA ch3 lvl9", 32'(c3), 18);

    do_reset(0, 0, 1'b0);
    for (int e = 0; e < 10; e++) clk1();
    step_div = 10'd1000;
    check("pwmB duty", 32'(duty_cycle), 32'(pk(10, 10, 8, 6)));
    clk1();
    pwm_count(20, c0, c1, c2, c3);
    check("pwmB ch0 lvl10", 32'(c0), 20);
    check("pwmB ch2 lvl8", 32'(c2), 16);
    check("pwmB ch3 lvl6", 32'(c3), 12);

    do_reset(1000, 0, 1'b0);
    clk1();
    pwm_count(20, c0, c1, c2, c3);
    check("pwmC ch0 lvl0", 32'(c0), 0);
    check("pwmC ch1 lvl2", 32'(c1), 4);

    // Pause and resume.
    do_reset(3, 0, 1'b0);
    ticks = 0;
    for (int e = 0; e < 30; e++) begin
      clk1();
      ticks += int'(step_tick);
    end
    check("pause ticks before", 32'(ticks), 7);
    snap = duty_cycle;
    en = 1'b0;
    ok_duty = 1'b1; ok_pwm = 1'b1; ok_tick = 1'b1;
    for (int e = 0; e < 50; e++) begin
      clk1();
      if (duty_cycle !== snap) ok_duty = 1'b0;
      if (pwm_out !== 4'b0) ok_pwm = 1'b0;
      if (step_tick !== 1'b0 || cycle_done !== 4'b0) ok_tick = 1'b0;
    end
    check("pause duty frozen", 32'(ok_duty), 1);
    check("pause pwm low", 32'(ok_pwm), 1);
    check("pause no pulses", 32'(ok_tick), 1);
    en = 1'b1;
    for (int e = 0; e < 70; e++) begin
      clk1();
      ticks += int'(step_tick);
    end
    check("resume tick total", 32'(ticks), 25);
    check("resume duty", 32'(duty_cycle), 32'(pk(2, 4, 6, 8)));

    // Reset during DOWN.
    do_reset(0, 0, 1'b0);
    for (int e = 0; e < 15; e++) clk1();
    check("pre-rst ch0", 32'(duty_cycle[3:0]), 7);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    check("mid-rst duty", 32'(duty_cycle), 32'(pk(0, 2, 4, 6)));
    check("mid-rst pwm", 32'(pwm_out), 0);
    check("mid-rst tick", 32'(step_tick), 0);
    check("mid-rst done", 32'(cycle_done), 0);

    // Mode switch while channels are in DOWN.
    do_reset(0, 0, 1'b0);
    for (int e = 0; e < 13; e++) clk1();
    check("mode pre duty", 32'(duty_cycle), 32'(pk(9, 7, 5, 3)));
    mode = 1'b1;
    clk1();
    check("mode switch duty", 32'(duty_cycle), 32'(pk(9, 7, 5, 3)));
    clk1();
    check("mode up duty", 32'(duty_cycle), 32'(pk(10, 8, 6, 4)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
